// File: rtl/multichannel_block_averager_pkg.sv
// Shared definitions for the block averager: scaling mode encodings and the
// floor-log2 helper that turns a block length into the scaling shift.
package multichannel_block_averager_pkg;

  localparam logic [1:0] MODE_SUM   = 2'd0;
  localparam logic [1:0] MODE_SHIFT = 2'd1;
  localparam logic [1:0] MODE_ROUND = 2'd2;

  function automatic logic [6:0] floor_log2(input logic [63:0] n);
    logic [6:0] k;
    k = '0;
    for (int i = 0; i < 64; i++) begin
      if (n[i]) k = 7'(i);
    end
    return k;
  endfunction

endpackage

// File: rtl/multichannel_block_averager_rr_arbiter.sv
// Round-robin picker: grants the first requester at or after the pointer, combinationally.
// The pointer moves past the granted channel only when advance is strobed.
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [CH_BITS-1:0]  grant,
  output logic                grant_valid
);

  logic [CH_BITS-1:0] ptr_q, ptr_d;
  logic [CH_BITS-1:0] idx_b;
  int                 idx;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    idx_b       = '0;
    for (int off = CHANNELS - 1; off >= 0; off--) begin
      idx = int'(ptr_q) + off;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      idx_b = CH_BITS'(idx);
      if (req[idx_b]) begin
        grant       = idx_b;
        grant_valid = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_valid) begin
      ptr_d = (int'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/multichannel_block_averager.sv
// Interleaved multi-channel block averager: per-channel sum over N samples, scaled, then
// round-robin onto a valid/ready port. Result appears 2 cycles after the last sample.
module multichannel_block_averager #(
  parameter int CHANNELS              = 4,
  parameter int CH_BITS               = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int AVERAGING_POINTS_BITS = 32,
  parameter int INPUT_DATA_BITS       = 16,
  parameter int SIGNED                = 1,
  parameter int OUTPUT_DATA_BITS      = INPUT_DATA_BITS + AVERAGING_POINTS_BITS
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [AVERAGING_POINTS_BITS-1:0] averaging_points,
  input  logic [1:0]                       mode,
  input  logic                             in_valid,
  input  logic [CH_BITS-1:0]               in_channel,
  input  logic [INPUT_DATA_BITS-1:0]       data_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CH_BITS-1:0]               out_channel,
  output logic [OUTPUT_DATA_BITS-1:0]      data_out,
  output logic [CHANNELS-1:0]              overrun
);

  import multichannel_block_averager_pkg::*;

  localparam int W  = OUTPUT_DATA_BITS;
  localparam int I  = INPUT_DATA_BITS;
  localparam int AP = AVERAGING_POINTS_BITS;

  logic                enable_prev_q, enable_prev_d;
  logic [AP-1:0]       n_q, n_d;
  logic [1:0]          mode_q, mode_d;
  logic [W-1:0]        sum_q [CHANNELS];
  logic [W-1:0]        sum_d [CHANNELS];
  logic [AP-1:0]       cnt_q [CHANNELS];
  logic [AP-1:0]       cnt_d [CHANNELS];
  logic [W-1:0]        res_q [CHANNELS];
  logic [W-1:0]        res_d [CHANNELS];
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] overrun_q, overrun_d;
  logic                out_valid_q, out_valid_d;
  logic [CH_BITS-1:0]  out_channel_q, out_channel_d;
  logic [W-1:0]        data_out_q, data_out_d;

  logic [AP-1:0]       n_cfg, n_eff;
  logic [1:0]          mode_cfg;
  logic [6:0]          k;
  logic [W-1:0]        ext, sum_next;
  logic                accept, load, advance, drained;
  logic [CHANNELS-1:0] req;
  logic [CH_BITS-1:0]  grant;
  logic                grant_valid;

  function automatic logic [W-1:0] scale(input logic [W-1:0] s, input logic [1:0] md,
                                         input logic [6:0] sh);
    logic [W-1:0]        r;
    logic signed [W-1:0] s_s;
    logic [W:0]          wide;
    logic signed [W:0]   wide_s;
    r = s;
    if (md == MODE_SHIFT) begin
      if (SIGNED != 0) begin
        s_s = signed'(s);
        s_s = s_s >>> sh;
        r   = unsigned'(s_s);
      end else begin
        r = s >> sh;
      end
    end else if (md == MODE_ROUND && sh != 7'd0) begin
      // One extra bit keeps the rounding bias from wrapping before the shift.
      wide = (SIGNED != 0) ? {s[W-1], s} : {1'b0, s};
      wide = wide + ({{W{1'b0}}, 1'b1} << (sh - 7'd1));
      if (SIGNED != 0) begin
        wide_s = signed'(wide);
        wide_s = wide_s >>> sh;
        r      = wide_s[W-1:0];
      end else begin
        wide = wide >> sh;
        r    = wide[W-1:0];
      end
    end
    return r;
  endfunction

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .CH_BITS  (CH_BITS)
  ) u_arb (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .advance     (advance),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    enable_prev_d = enable;
    n_d           = n_q;
    mode_d        = mode_q;
    n_cfg         = n_q;
    mode_cfg      = mode_q;
    // On the enable rising edge the fresh settings apply immediately.
    if (enable && !enable_prev_q) begin
      n_d      = averaging_points;
      mode_d   = mode;
      n_cfg    = averaging_points;
      mode_cfg = mode;
    end
    n_eff  = (n_cfg == '0) ? AP'(1) : n_cfg;
    k      = floor_log2(64'(n_eff));
    ext    = (SIGNED != 0) ? {{(W-I){data_in[I-1]}}, data_in} : {{(W-I){1'b0}}, data_in};
    accept = enable && in_valid && (int'(in_channel) < CHANNELS);

    req     = pend_q & {CHANNELS{enable}};
    load    = !out_valid_q || out_ready;
    advance = load && grant_valid;

    sum_next  = '0;
    drained   = 1'b0;
    pend_d    = pend_q;
    overrun_d = overrun_q;
    for (int c = 0; c < CHANNELS; c++) begin
      sum_d[c] = sum_q[c];
      cnt_d[c] = cnt_q[c];
      res_d[c] = res_q[c];
      drained  = advance && (int'(grant) == c);
      if (drained) pend_d[c] = 1'b0;
      if (accept && int'(in_channel) == c) begin
        sum_next = (cnt_q[c] == '0) ? ext : sum_q[c] + ext;
        sum_d[c] = sum_next;
        if (cnt_q[c] == n_eff - 1'b1) begin
          cnt_d[c]  = '0;
          res_d[c]  = scale(sum_next, mode_cfg, k);
          pend_d[c] = 1'b1;
          if (pend_q[c] && !drained) overrun_d[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end
      if (!enable) begin
        sum_d[c]     = '0;
        cnt_d[c]     = '0;
        pend_d[c]    = 1'b0;
        overrun_d[c] = 1'b0;
      end
    end

    out_valid_d   = out_valid_q;
    out_channel_d = out_channel_q;
    data_out_d    = data_out_q;
    if (load) begin
      if (grant_valid) begin
        out_valid_d   = 1'b1;
        out_channel_d = grant;
        data_out_d    = res_q[grant];
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enable_prev_q <= 1'b0;
      n_q           <= '0;
      mode_q        <= MODE_SUM;
      pend_q        <= '0;
      overrun_q     <= '0;
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      data_out_q    <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        sum_q[c] <= '0;
        cnt_q[c] <= '0;
        res_q[c] <= '0;
      end
    end else begin
      enable_prev_q <= enable_prev_d;
      n_q           <= n_d;
      mode_q        <= mode_d;
      pend_q        <= pend_d;
      overrun_q     <= overrun_d;
      out_valid_q   <= out_valid_d;
      out_channel_q <= out_channel_d;
      data_out_q    <= data_out_d;
      sum_q         <= sum_d;
      cnt_q         <= cnt_d;
      res_q         <= res_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_channel = out_channel_q;
  assign data_out    = data_out_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_multichannel_block_averager.sv
// Scoreboard bench: stimulus pushes reference-model results per channel, a forked
// monitor pops and compares on every output handshake of the signed and unsigned instances.
module tb_multichannel_block_averager;

  localparam int CH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable, enable_u;
  logic [31:0] averaging_points;
  logic [1:0]  mode;
  logic        in_valid;
  logic [1:0]  in_channel;
  logic [15:0] data_in;
  logic        out_ready;
  logic        out_valid, out_valid_u;
  logic [1:0]  out_channel, out_channel_u;
  logic [47:0] data_out, data_out_u;
  logic [3:0]  overrun, overrun_u;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_cyc = 0;
  int last_hs = 0;
  int vcount = 0;
  int out_log[$];
  int hs_log[$];

  logic [47:0] exp_q [2*CH][$];
  int          pq [CH][$];
  int          cfg_n = 1;
  int          cfg_mode = 0;
  bit          cfg_sgn = 1'b1;
  int          cur_u = 0;
  bit          skip_push = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  multichannel_block_averager #(.CHANNELS(4), .SIGNED(1)) dut (
    .clock(clock), .reset(reset), .enable(enable), .averaging_points(averaging_points),
    .mode(mode), .in_valid(in_valid), .in_channel(in_channel), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
    .data_out(data_out), .overrun(overrun)
  );

  multichannel_block_averager #(.CHANNELS(4), .SIGNED(0)) dut_u (
    .clock(clock), .reset(reset), .enable(enable_u), .averaging_points(averaging_points),
    .mode(mode), .in_valid(in_valid), .in_channel(in_channel), .data_in(data_in),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_channel(out_channel_u),
    .data_out(data_out_u), .overrun(overrun_u)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Block result from plain arithmetic: sum, then divide by the largest power of two <= N.
  function automatic logic [47:0] expected_result(input longint s);
    int     n;
    int     k;
    longint p;
    longint r;
    n = (cfg_n == 0) ? 1 : cfg_n;
    k = 0;
    while ((longint'(2) << k) <= longint'(n)) k++;
    p = longint'(1) << k;
    case (cfg_mode)
      1:       r = floor_div(s, p);
      2:       r = floor_div(s + p / 2, p);
      default: r = s;
    endcase
    return r[47:0];
  endfunction

  task automatic model_accept(input int ch, input logic [15:0] d);
    int     n;
    longint s;
    n = (cfg_n == 0) ? 1 : cfg_n;
    pq[ch].push_back(cfg_sgn ? int'($signed(d)) : int'(d));
    if (pq[ch].size() >= n) begin
      s = 0;
      foreach (pq[ch][i]) s += longint'(pq[ch][i]);
      if (!skip_push) exp_q[cur_u*CH + ch].push_back(expected_result(s));
      pq[ch].delete();
    end
  endtask

  task automatic send(input int ch, input int val);
    @(posedge clock); #1;
    in_valid   = 1'b1;
    in_channel = 2'(ch);
    data_in    = 16'(val);
    last_cyc   = cyc;
    model_accept(ch, data_in);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      in_valid = 1'b0;
    end
  endtask

  // Drop enable for a cycle, latch new settings on the rising edge, then scramble the inputs.
  task automatic configure(input int u, input int n, input int md);
    @(posedge clock); #1;
    in_valid = 1'b0;
    enable   = 1'b0;
    enable_u = 1'b0;
    averaging_points = 32'(n);
    mode     = 2'(md);
    @(posedge clock); #1;
    if (u != 0) enable_u = 1'b1;
    else        enable   = 1'b1;
    @(posedge clock); #1;
    averaging_points = $urandom;
    mode     = 2'($urandom);
    cfg_n    = n;
    cfg_mode = md;
    cfg_sgn  = (u == 0);
    cur_u    = u;
    foreach (pq[c]) pq[c].delete();
  endtask

  task automatic expect_pop(input int u, input logic [1:0] ch, input logic [47:0] d);
    int          qi;
    logic [47:0] e;
    qi = u*CH + int'(ch);
    if (exp_q[qi].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_output: dut=%0d ch=%0d got=%0d expected no result", u, ch, d);
    end else begin
      e = exp_q[qi].pop_front();
      check($sformatf("result_dut%0d_ch%0d", u, ch), longint'(d), longint'(e));
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (out_valid) vcount++;
        if (out_valid && out_ready) begin
          expect_pop(0, out_channel, data_out);
          out_log.push_back(int'(out_channel));
          hs_log.push_back(cyc);
          last_hs = cyc;
        end
        if (out_valid_u && out_ready) expect_pop(1, out_channel_u, data_out_u);
      end
    end
  endtask

  task automatic check_order(input string name, input int base, input int exp_ch[$]);
    check({name, "_count"}, out_log.size() - base, exp_ch.size());
    if (out_log.size() - base == exp_ch.size()) begin
      foreach (exp_ch[i]) check($sformatf("%s_%0d", name, i), out_log[base+i], exp_ch[i]);
    end
  endtask

  initial begin
    int v0;
    int o0;
    int nlist[6];
    nlist = '{1, 2, 3, 4, 5, 8};
    reset = 1'b1; enable = 1'b0; enable_u = 1'b0; averaging_points = '0; mode = '0;
    in_valid = 1'b0; in_channel = '0; data_in = '0; out_ready = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_out_channel", out_channel, 0);
    check("rst_overrun", overrun, 0);
    check("rst_u_out_valid", out_valid_u, 0);
    check("rst_u_data_out", data_out_u, 0);
    check("rst_u_overrun", overrun_u, 0);
    reset = 1'b0;

    // Signed shift-truncate: 10+20+30-4 = 56, >>>2 = 14, two cycles after the last sample.
    configure(0, 4, 1);
    v0 = vcount;
    send(0, 10); send(0, 20); send(0, 30); send(0, -4);
    idle(6);
    check("t1_latency", last_hs - last_cyc, 2);
    check("t1_valid_cycles", vcount - v0, 1);
    check("t1_data", data_out, 14);
    check("t1_channel", out_channel, 0);

    // Sum 6 in round, truncate and raw modes.
    for (int md = 2; md >= 0; md--) begin
      configure(0, 4, md);
      send(1, 1); send(1, 1); send(1, 1); send(1, 3);
      idle(6);
    end
    check("t2_sum_mode0", data_out, 6);

    // N=1 interleaved, every cycle.
    configure(0, 1, 0);
    o0 = out_log.size();
    send(0, 1); send(1, 2); send(2, 3); send(3, 4);
    idle(8);
    check_order("t3_order", o0, '{0, 1, 2, 3});
    check("t3_overrun", overrun, 0);

    // Backpressure: first block held, second overwritten by the third.
    configure(0, 2, 0);
    out_ready = 1'b0;
    send(2, 3); send(2, 5);
    skip_push = 1'b1;
    send(2, 1); send(2, 1);
    skip_push = 1'b0;
    send(2, 7); send(2, 7);
    idle(3);
    check("t4_overrun", overrun, 4'b0100);
    check("t4_out_valid_held", out_valid, 1);
    check("t4_data_held", data_out, 8);
    out_ready = 1'b1;
    idle(6);
    check("t4_overrun_sticky", overrun, 4'b0100);

    // All channels pending together, then ch0+ch3 with the pointer back at 0.
    configure(0, 1, 0);
    check("t5_overrun_cleared", overrun, 0);
    out_ready = 1'b0;
    send(0, 10); send(1, 11); send(2, 12); send(3, 13);
    idle(3);
    o0 = out_log.size();
    out_ready = 1'b1;
    idle(6);
    check_order("t5_all", o0, '{0, 1, 2, 3});
    if (hs_log.size() >= o0 + 4) check("t5_back_to_back", hs_log[o0+3] - hs_log[o0], 3);
    out_ready = 1'b0;
    send(3, 20); send(3, 21); send(0, 22);
    idle(3);
    o0 = out_log.size();
    out_ready = 1'b1;
    idle(6);
    check_order("t5_pair", o0, '{3, 0, 3});
    check("t5_no_overrun", overrun, 0);

    // Unsigned instance, plus enable dropped mid-block.
    configure(1, 2, 1);
    send(0, 16'hFFFF); send(0, 16'hFFFF);
    idle(5);
    check("t6_unsigned", data_out_u, 65535);
    send(1, 100);
    configure(1, 2, 1);
    send(1, 6); send(1, 8);
    idle(5);
    check("t6_restart", data_out_u, 7);
    check("t6_u_overrun", overrun_u, 0);

    // Randomised blocks across all modes and block lengths.
    for (int b = 0; b < 6; b++) begin
      idle(8);
      configure(0, nlist[$urandom_range(0, 5)], int'($urandom_range(0, 3)));
      repeat (80) begin
        if ($urandom_range(0, 3) != 0) send(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)));
        else idle(1);
      end
      idle(10);
      check($sformatf("rand%0d_overrun", b), overrun, 0);
    end

    idle(10);
    for (int q = 0; q < 2*CH; q++) check($sformatf("missing_results_q%0d", q), exp_q[q].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
